// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: Moore sequencer for the iterative AES round datapath (LOAD, SUB, SHIFT, MIX, ARK, DONE).
// Optional abort input enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       out_ready,
`ifdef AES_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       ld_state,
    output logic       en_sub,
    output logic       en_shift,
    output logic       en_mix,
    output logic       en_ark,
    output logic [3:0] round,
    output logic       last_round,
    output logic       out_valid
);
    typedef enum logic [2:0] {IDLE, LOAD, SUB, SHIFT, MIX, ARK, DONE} state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    state_t     r_state, w_next;
    logic [3:0] r_round, w_round;
    logic       w_last;

    assign w_last = (r_round == NR_L);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_round <= 4'd0;
        end else begin
            r_state <= w_next;
            r_round <= w_round;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_round = r_round;
        case (r_state)
            IDLE:    begin w_next = start ? LOAD : IDLE; w_round = 4'd0; end
            LOAD:    begin w_next = SUB; w_round = 4'd1; end
            SUB:     w_next = SHIFT;
            SHIFT:   w_next = w_last ? ARK : MIX;
            MIX:     w_next = ARK;
            ARK:     begin w_next = w_last ? DONE : SUB; w_round = w_last ? r_round : r_round + 4'd1; end
            DONE:    begin w_next = out_ready ? IDLE : DONE; w_round = out_ready ? 4'd0 : r_round; end
            default: begin w_next = IDLE; w_round = 4'd0; end
        endcase
        // an out-of-range counter can only come from corruption; recover to IDLE
        if (r_round > NR_L) begin
            w_next  = IDLE;
            w_round = 4'd0;
        end
`ifdef AES_CTRL_ABORT_EN
        if (abort && r_state != IDLE) begin
            w_next  = IDLE;
            w_round = 4'd0;
        end
`endif
    end

    assign busy       = (r_state != IDLE);
    assign ld_state   = (r_state == LOAD);
    assign en_sub     = (r_state == SUB);
    assign en_shift   = (r_state == SHIFT);
    assign en_mix     = (r_state == MIX);
    assign en_ark     = (r_state == ARK) || (r_state == LOAD);
    assign round      = r_round;
    assign last_round = w_last;
    assign out_valid  = (r_state == DONE);
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed scoreboard bench for aes_round_ctrl with NR = 10 and NR = 14 instances.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic start10 = 1'b0;
    logic start14 = 1'b0;
    logic out_ready = 1'b0;
    logic abort = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [11:0] q[$];

    logic busy10, ld10, sub10, sh10, mix10, ark10, last10, val10;
    logic busy14, ld14, sub14, sh14, mix14, ark14, last14, val14;
    logic [3:0] rnd10, rnd14;
    logic [11:0] v10, v14;

    assign v10 = {busy10, ld10, sub10, sh10, mix10, ark10, rnd10, last10, val10};
    assign v14 = {busy14, ld14, sub14, sh14, mix14, ark14, rnd14, last14, val14};

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10)) u10 (
        .clk(clk), .clr(clr), .start(start10), .out_ready(out_ready),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy10), .ld_state(ld10), .en_sub(sub10), .en_shift(sh10), .en_mix(mix10),
        .en_ark(ark10), .round(rnd10), .last_round(last10), .out_valid(val10)
    );

    aes_round_ctrl #(.NR(14)) u14 (
        .clk(clk), .clr(clr), .start(start14), .out_ready(out_ready),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy14), .ld_state(ld14), .en_sub(sub14), .en_shift(sh14), .en_mix(mix14),
        .en_ark(ark14), .round(rnd14), .last_round(last14), .out_valid(val14)
    );

    // expected outputs k cycles after the start edge, derived from the timing schedule
    function automatic logic [11:0] exp_vec(input int nr, input int k);
        logic b, ld, su, sh, mi, ar, va;
        logic [3:0] rd;
        int j, r, p;
        {b, ld, su, sh, mi, ar, va} = 7'b0;
        rd = 4'd0;
        b = 1'b1;
        if (k == 1) begin
            ld = 1'b1;
            ar = 1'b1;
        end else if (k <= 4 * nr) begin
            j = k - 2;
            r = j / 4 + 1;
            p = j % 4;
            rd = 4'(r);
            su = (p == 0);
            sh = (p == 1);
            mi = (r != nr) && (p == 2);
            ar = (r == nr) ? (p == 2) : (p == 3);
        end else begin
            rd = 4'(nr);
            va = 1'b1;
        end
        return {b, ld, su, sh, mi, ar, rd, (rd == 4'(nr)), va};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 none, 1 start pulse, 2 clr, 3 abort, 4 abort+clr, 5 start in DONE; applied during cycle g
    task automatic run(input int nr, input int n_wait, input int g, input int kind);
        int last_k, n, mix_c, ark_c;
        logic [11:0] obs;
        mix_c = 0;
        ark_c = 0;
        last_k = 4 * nr + 1 + n_wait;
        n = (kind >= 2 && kind <= 4) ? g : last_k;
        for (int k = 1; k <= n; k++) q.push_back(exp_vec(nr, k));
        for (int k = 0; k < 3; k++) q.push_back(12'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (nr == 14) start14 = 1'b1; else start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        start14 = 1'b0;
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            obs = (nr == 14) ? v14 : v10;
            check($sformatf("nr%0d_kind%0d_k%0d", nr, kind, k), obs, q.pop_front());
            mix_c += int'(obs[7]);
            ark_c += int'(obs[6]);
            out_ready = (k >= last_k);
            start10 = 1'b0;
            start14 = 1'b0;
            clr = 1'b0;
            abort = 1'b0;
            if (k == g) begin
                if (kind == 1 || kind == 5) begin
                    if (nr == 14) start14 = 1'b1; else start10 = 1'b1;
                end
                if (kind == 2 || kind == 4) clr = 1'b1;
                if (kind == 3 || kind == 4) abort = 1'b1;
            end
        end
        {start10, start14, clr, abort, out_ready} = 5'b0;
        if (kind == 0) begin
            check($sformatf("nr%0d_mix_count", nr), 12'(mix_c), 12'(nr - 1));
            check($sformatf("nr%0d_ark_count", nr), 12'(ark_c), 12'(nr + 1));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_nr10", v10, 12'd0);
        check("reset_nr14", v14, 12'd0);
        clr = 1'b0;
        run(10, 0, 0, 0);
        run(14, 5, 0, 0);
        run(10, 0, 12, 1);
        run(10, 0, 23, 2);
        run(10, 0, 0, 0);
        run(10, 0, 41, 5);
        run(10, 0, 0, 0);
`ifdef AES_CTRL_ABORT_EN
        run(10, 0, 37, 3);
        run(10, 0, 15, 4);
        run(14, 0, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
